draw_sequencer: RTL and testbench

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/draw_pkg.sv | 36 +++
 rtl/obj_table.sv | 50 +++++
 rtl/draw_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_draw_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the draw sequencer.
//   state_t      : sequencer FSM states
//   obj_t        : one object slot record (x, y, w, h, colour, valid)
//   obj_drawable : a slot is drawn/erased only when valid with non-zero size
package draw_pkg;

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned W_W = 5;
    localparam int unsigned H_W = 5;
    localparam int unsigned C_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StEraseSetup,
        StEraseWait,
        StCommit,
        StDrawSetup,
        StDrawWait,
        StFinish
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [W_W-1:0] w;
        logic [H_W-1:0] h;
        logic [C_W-1:0] c;
        logic           valid;
    } obj_t;

    function automatic logic obj_drawable(input obj_t o);
        return o.valid && (o.w != '0) && (o.h != '0);
    endfunction

endpackage

// File: rtl/obj_table.sv
// Double-buffered object table: a shadow table written at any time and a
// current table that snapshots the whole shadow on a commit strobe.
//   clk, reset  : clock, asynchronous active-high reset (clears every slot)
//   i_we        : shadow write strobe, i_wr_idx/i_wr_obj select slot and data
//   i_commit    : copy shadow -> current at the next rising edge
//   i_rd_idx    : slot to read
//   o_rd_obj    : value current[i_rd_idx] will hold after this edge, so the
//                 sequencer can register its outputs without a read bubble
module obj_table
    import draw_pkg::*;
#(
    parameter int unsigned NUM_OBJ = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  obj_t             i_wr_obj,
    input  logic             i_commit,
    input  logic [IDX_W-1:0] i_rd_idx,
    output obj_t             o_rd_obj
);

    obj_t r_shadow  [NUM_OBJ];
    obj_t r_current [NUM_OBJ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_shadow[i]  <= '0;
                r_current[i] <= '0;
            end
        end else begin
            // Commit samples the shadow before any same-cycle write lands.
            if (i_commit) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    r_current[i] <= r_shadow[i];
                end
            end
            if (i_we) begin
                r_shadow[i_wr_idx] <= i_wr_obj;
            end
        end
    end

    // Look-ahead read: during a commit, current is about to become shadow.
    assign o_rd_obj = i_commit ? r_shadow[i_rd_idx] : r_current[i_rd_idx];

endmodule

// File: rtl/draw_sequencer.sv
// Frame redraw sequencer. On frame_tick it erases every drawable object of
// the current table (colour 0), commits the shadow table into current, then
// draws every drawable object with its own colour, handshaking each object
// with a downstream rectangle drawer via draw_en/draw_done.
//   clk, reset                 : clock, asynchronous active-high reset
//   frame_tick                 : start a pass (ignored and flagged while busy)
//   obj_we, obj_idx, obj_*     : shadow table write port
//   draw_done                  : drawer finished the presented rectangle
//   x_out..c_out, draw_en      : rectangle presented to the drawer
//   busy, frame_done, overrun  : pass active, pass-end pulse, dropped tick
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned NUM_OBJ = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             obj_we,
    input  logic [IDX_W-1:0] obj_idx,
    input  logic [X_W-1:0]   obj_x,
    input  logic [Y_W-1:0]   obj_y,
    input  logic [W_W-1:0]   obj_w,
    input  logic [H_W-1:0]   obj_h,
    input  logic [C_W-1:0]   obj_c,
    input  logic             obj_valid,
    input  logic             draw_done,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [W_W-1:0]   w_out,
    output logic [H_W-1:0]   h_out,
    output logic [C_W-1:0]   c_out,
    output logic             draw_en,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_last;
    logic             w_commit;
    obj_t             w_wr_obj;
    obj_t             w_rd_obj;
    logic             r_drawable;

    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [W_W-1:0]   r_w;
    logic [H_W-1:0]   r_h;
    logic [C_W-1:0]   r_c;
    logic             r_draw_en;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_overrun;

    assign w_wr_obj.x     = obj_x;
    assign w_wr_obj.y     = obj_y;
    assign w_wr_obj.w     = obj_w;
    assign w_wr_obj.h     = obj_h;
    assign w_wr_obj.c     = obj_c;
    assign w_wr_obj.valid = obj_valid;

    assign w_commit = (r_state == StCommit);
    assign w_last   = (r_idx == IDX_W'(NUM_OBJ - 1));

    obj_table #(
        .NUM_OBJ (NUM_OBJ),
        .IDX_W   (IDX_W)
    ) u_obj_table (
        .clk      (clk),
        .reset    (reset),
        .i_we     (obj_we),
        .i_wr_idx (obj_idx),
        .i_wr_obj (w_wr_obj),
        .i_commit (w_commit),
        .i_rd_idx (w_idx_next),
        .o_rd_obj (w_rd_obj)
    );

    // Next state and slot index.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        unique case (r_state)
            StIdle: begin
                if (frame_tick) begin
                    w_state_next = StEraseSetup;
                    w_idx_next   = '0;
                end
            end
            StEraseSetup: begin
                if (r_drawable) begin
                    w_state_next = StEraseWait;
                end else if (w_last) begin
                    w_state_next = StCommit;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end
            StEraseWait: begin
                if (draw_done) begin
                    if (w_last) begin
                        w_state_next = StCommit;
                    end else begin
                        w_state_next = StEraseSetup;
                        w_idx_next   = r_idx + IDX_W'(1);
                    end
                end
            end
            StCommit: begin
                w_state_next = StDrawSetup;
                w_idx_next   = '0;
            end
            StDrawSetup: begin
                if (r_drawable) begin
                    w_state_next = StDrawWait;
                end else if (w_last) begin
                    w_state_next = StFinish;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end
            StDrawWait: begin
                if (draw_done) begin
                    if (w_last) begin
                        w_state_next = StFinish;
                    end else begin
                        w_state_next = StDrawSetup;
                        w_idx_next   = r_idx + IDX_W'(1);
                    end
                end
            end
            StFinish: begin
                w_state_next = StIdle;
                w_idx_next   = '0;
            end
            default: begin
                w_state_next = StIdle;
                w_idx_next   = '0;
            end
        endcase
    end

    // State plus registered outputs, all loaded from the next-state view so
    // each output reflects the state it is shown in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_drawable   <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_c          <= '0;
            r_draw_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_drawable   <= obj_drawable(w_rd_obj);
            r_draw_en    <= (w_state_next == StEraseWait) || (w_state_next == StDrawWait);
            r_busy       <= (w_state_next != StIdle);
            r_frame_done <= (w_state_next == StFinish);
            r_overrun    <= frame_tick && r_busy;

            r_x <= '0;
            r_y <= '0;
            r_w <= '0;
            r_h <= '0;
            r_c <= '0;
            unique case (w_state_next)
                StEraseSetup, StEraseWait: begin
                    r_x <= w_rd_obj.x;
                    r_y <= w_rd_obj.y;
                    r_w <= w_rd_obj.w;
                    r_h <= w_rd_obj.h;
                end
                StDrawSetup, StDrawWait: begin
                    r_x <= w_rd_obj.x;
                    r_y <= w_rd_obj.y;
                    r_w <= w_rd_obj.w;
                    r_h <= w_rd_obj.h;
                    r_c <= w_rd_obj.c;
                end
                default: ;
            endcase
        end
    end

    assign x_out      = r_x;
    assign y_out      = r_y;
    assign w_out      = r_w;
    assign h_out      = r_h;
    assign c_out      = r_c;
    assign draw_en    = r_draw_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: a small drawer model acknowledges each
// draw_en window on its third cycle; each scenario task checks the captured
// windows and pass timing against hand-computed values.
module tb_draw_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       obj_we;
    logic [2:0] obj_idx;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic [4:0] obj_w;
    logic [4:0] obj_h;
    logic [2:0] obj_c;
    logic       obj_valid;
    logic       draw_done;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [4:0] w_out;
    logic [4:0] h_out;
    logic [2:0] c_out;
    logic       draw_en;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;

    // Per-pass capture.
    logic [7:0] win_x [16];
    logic [6:0] win_y [16];
    logic [4:0] win_w [16];
    logic [4:0] win_h [16];
    logic [2:0] win_c [16];
    int         win_cyc [16];
    int         n_win, n_fd, n_ovr, done_cyc, idle_cyc;
    bit         timed_out, unstable;

    draw_sequencer #(
        .NUM_OBJ (8),
        .IDX_W   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .obj_we     (obj_we),
        .obj_idx    (obj_idx),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_w      (obj_w),
        .obj_h      (obj_h),
        .obj_c      (obj_c),
        .obj_valid  (obj_valid),
        .draw_done  (draw_done),
        .x_out      (x_out),
        .y_out      (y_out),
        .w_out      (w_out),
        .h_out      (h_out),
        .c_out      (c_out),
        .draw_en    (draw_en),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_obj(input logic [2:0] idx, input logic [7:0] x, input logic [6:0] y,
                             input logic [4:0] w, input logic [4:0] h, input logic [2:0] c,
                             input logic v);
        obj_idx = idx; obj_x = x; obj_y = y; obj_w = w; obj_h = h; obj_c = c; obj_valid = v;
        obj_we = 1'b1;
        step();
        obj_we = 1'b0;
    endtask

    // Runs one pass. inj_kind 1: frame_tick at the start of window inj_at.
    // inj_kind 2: write slot2 (50,60,2,2,c=3) in pass cycle inj_at.
    // Cycle 1 is the first cycle after the edge that samples frame_tick.
    task automatic run_pass(input int inj_kind, input int inj_at);
        bit in_win;
        int wait_cnt;
        int cyc;
        n_win = 0; n_fd = 0; n_ovr = 0; done_cyc = -1; idle_cyc = -1;
        timed_out = 0; unstable = 0; in_win = 0; wait_cnt = 0;
        frame_tick = 1'b1;
        step();
        cyc = 1;
        while (idle_cyc < 0 && cyc < 400) begin
            frame_tick = 1'b0; obj_we = 1'b0; draw_done = 1'b0;
            if (frame_done) begin n_fd++; done_cyc = cyc; end
            if (overrun) n_ovr++;
            if (draw_en) begin
                if (!in_win) begin
                    if (inj_kind == 1 && n_win == inj_at) frame_tick = 1'b1;
                    if (n_win < 16) begin
                        win_x[n_win] = x_out; win_y[n_win] = y_out; win_w[n_win] = w_out;
                        win_h[n_win] = h_out; win_c[n_win] = c_out; win_cyc[n_win] = cyc;
                    end
                    n_win++; in_win = 1; wait_cnt = 0;
                end else begin
                    if (n_win <= 16 && {x_out, y_out, w_out, h_out, c_out} !==
                        {win_x[n_win-1], win_y[n_win-1], win_w[n_win-1], win_h[n_win-1],
                         win_c[n_win-1]}) unstable = 1;
                    wait_cnt++;
                end
                if (wait_cnt == 2) draw_done = 1'b1;
            end else begin
                in_win = 0;
            end
            if (inj_kind == 2 && cyc == inj_at) begin
                obj_idx = 3'd2; obj_x = 8'd50; obj_y = 7'd60; obj_w = 5'd2; obj_h = 5'd2;
                obj_c = 3'd3; obj_valid = 1'b1; obj_we = 1'b1;
            end
            if (!busy) idle_cyc = cyc;
            else begin step(); cyc++; end
        end
        if (idle_cyc < 0) timed_out = 1;
        frame_tick = 1'b0; obj_we = 1'b0; draw_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        frame_tick = 1'b1;
        step(); step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if ({draw_en, frame_done, overrun} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b want 000", {draw_en, frame_done, overrun}); end
        n_vec++; if ({x_out, y_out, w_out, h_out, c_out} !== 28'd0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {x_out, y_out, w_out, h_out, c_out}); end
        frame_tick = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_idle_pass();
        run_pass(0, 0);
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL idle_timeout: got %b want 0", timed_out); end
        n_vec++; if (n_win !== 0) begin n_err++; $display("FAIL idle_nwin: got %0d want 0", n_win); end
        n_vec++; if (done_cyc !== 18) begin n_err++; $display("FAIL idle_done_cyc: got %0d want 18", done_cyc); end
        n_vec++; if (idle_cyc !== 19) begin n_err++; $display("FAIL idle_busy_low: got %0d want 19", idle_cyc); end
        n_vec++; if (n_fd !== 1) begin n_err++; $display("FAIL idle_nfd: got %0d want 1", n_fd); end
    endtask

    task automatic test_single_object();
        write_obj(3'd0, 8'd10, 7'd20, 5'd4, 5'd3, 3'b100, 1'b1);
        run_pass(0, 0);
        n_vec++; if (n_win !== 1) begin n_err++; $display("FAIL single_nwin: got %0d want 1", n_win); end
        n_vec++; if ({win_x[0], win_y[0], win_w[0], win_h[0], win_c[0]} !== {8'd10, 7'd20, 5'd4, 5'd3, 3'b100}) begin
            n_err++; $display("FAIL single_win: got %0d/%0d/%0d/%0d/%0d want 10/20/4/3/4",
                              win_x[0], win_y[0], win_w[0], win_h[0], win_c[0]); end
        n_vec++; if (win_cyc[0] !== 11) begin n_err++; $display("FAIL single_win_cyc: got %0d want 11", win_cyc[0]); end
        n_vec++; if (unstable !== 1'b0) begin n_err++; $display("FAIL single_stable: got %b want 0", unstable); end
        n_vec++; if (done_cyc !== 21) begin n_err++; $display("FAIL single_done_cyc: got %0d want 21", done_cyc); end
        n_vec++; if (n_fd !== 1) begin n_err++; $display("FAIL single_nfd: got %0d want 1", n_fd); end
    endtask

    task automatic test_move();
        write_obj(3'd0, 8'd12, 7'd20, 5'd4, 5'd3, 3'b100, 1'b1);
        run_pass(0, 0);
        n_vec++; if (n_win !== 2) begin n_err++; $display("FAIL move_nwin: got %0d want 2", n_win); end
        n_vec++; if ({win_x[0], win_y[0], win_c[0]} !== {8'd10, 7'd20, 3'b000}) begin
            n_err++; $display("FAIL move_erase: got %0d/%0d c=%0d want 10/20 c=0", win_x[0], win_y[0], win_c[0]); end
        n_vec++; if ({win_x[1], win_y[1], win_c[1]} !== {8'd12, 7'd20, 3'b100}) begin
            n_err++; $display("FAIL move_draw: got %0d/%0d c=%0d want 12/20 c=4", win_x[1], win_y[1], win_c[1]); end
        n_vec++; if (unstable !== 1'b0) begin n_err++; $display("FAIL move_stable: got %b want 0", unstable); end
    endtask

    task automatic test_skip_order();
        write_obj(3'd0, 8'd12, 7'd20, 5'd4, 5'd3, 3'b100, 1'b0);
        write_obj(3'd1, 8'd30, 7'd40, 5'd5, 5'd6, 3'd2, 1'b1);
        write_obj(3'd3, 8'd70, 7'd11, 5'd0, 5'd4, 3'd7, 1'b1);
        write_obj(3'd5, 8'd90, 7'd33, 5'd1, 5'd1, 3'd6, 1'b1);
        run_pass(0, 0);
        n_vec++; if (n_win !== 3) begin n_err++; $display("FAIL skipA_nwin: got %0d want 3", n_win); end
        n_vec++; if ({win_x[0], win_c[0], win_x[1], win_x[2]} !== {8'd12, 3'd0, 8'd30, 8'd90}) begin
            n_err++; $display("FAIL skipA_order: got x %0d,%0d,%0d want 12,30,90", win_x[0], win_x[1], win_x[2]); end
        run_pass(0, 0);
        n_vec++; if (n_win !== 4) begin n_err++; $display("FAIL skipB_nwin: got %0d want 4", n_win); end
        n_vec++; if ({win_x[0], win_x[1], win_x[2], win_x[3]} !== {8'd30, 8'd90, 8'd30, 8'd90}) begin
            n_err++; $display("FAIL skipB_order: got x %0d,%0d,%0d,%0d want 30,90,30,90",
                              win_x[0], win_x[1], win_x[2], win_x[3]); end
        n_vec++; if ({win_c[0], win_c[1], win_c[2], win_c[3]} !== {3'd0, 3'd0, 3'd2, 3'd6}) begin
            n_err++; $display("FAIL skipB_colour: got %0d,%0d,%0d,%0d want 0,0,2,6",
                              win_c[0], win_c[1], win_c[2], win_c[3]); end
        n_vec++; if ({win_y[3], win_w[3], win_h[3]} !== {7'd33, 5'd1, 5'd1}) begin
            n_err++; $display("FAIL skipB_slot5: got %0d/%0d/%0d want 33/1/1", win_y[3], win_w[3], win_h[3]); end
    endtask

    task automatic test_overrun();
        run_pass(1, 2);
        n_vec++; if (n_ovr !== 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", n_ovr); end
        n_vec++; if (n_win !== 4) begin n_err++; $display("FAIL ovr_nwin: got %0d want 4", n_win); end
        n_vec++; if (n_fd !== 1) begin n_err++; $display("FAIL ovr_nfd: got %0d want 1", n_fd); end
        n_vec++; if ({win_x[2], win_c[2]} !== {8'd30, 3'd2}) begin
            n_err++; $display("FAIL ovr_win: got %0d c=%0d want 30 c=2", win_x[2], win_c[2]); end
        step(); step(); step();
        n_vec++; if ({busy, draw_en, overrun} !== 3'b000) begin
            n_err++; $display("FAIL ovr_no_restart: got %b want 000", {busy, draw_en, overrun}); end
    endtask

    task automatic test_commit_write();
        write_obj(3'd1, 8'd30, 7'd40, 5'd5, 5'd6, 3'd2, 1'b0);
        write_obj(3'd3, 8'd70, 7'd11, 5'd0, 5'd4, 3'd7, 1'b0);
        write_obj(3'd5, 8'd90, 7'd33, 5'd1, 5'd1, 3'd6, 1'b0);
        run_pass(0, 0);
        n_vec++; if (n_win !== 2) begin n_err++; $display("FAIL clear_nwin: got %0d want 2", n_win); end
        run_pass(2, 9);
        n_vec++; if (n_win !== 0) begin n_err++; $display("FAIL cw_this_pass: got %0d want 0", n_win); end
        n_vec++; if (done_cyc !== 18) begin n_err++; $display("FAIL cw_done_cyc: got %0d want 18", done_cyc); end
        run_pass(0, 0);
        n_vec++; if (n_win !== 1) begin n_err++; $display("FAIL cw_next_nwin: got %0d want 1", n_win); end
        n_vec++; if ({win_x[0], win_y[0], win_w[0], win_h[0], win_c[0]} !== {8'd50, 7'd60, 5'd2, 5'd2, 3'd3}) begin
            n_err++; $display("FAIL cw_next_win: got %0d/%0d/%0d/%0d/%0d want 50/60/2/2/3",
                              win_x[0], win_y[0], win_w[0], win_h[0], win_c[0]); end
        n_vec++; if (win_cyc[0] !== 13) begin n_err++; $display("FAIL cw_win_cyc: got %0d want 13", win_cyc[0]); end
    endtask

    task automatic test_reset_mid_pass();
        int n;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n = 0;
        while (!draw_en && n < 50) begin step(); n++; end
        n_vec++; if (draw_en !== 1'b1) begin n_err++; $display("FAIL rst_mid_reach_wait: got %b want 1", draw_en); end
        n_vec++; if (n !== 3) begin n_err++; $display("FAIL rst_mid_wait_cyc: got %0d want 3", n); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if ({draw_en, busy, frame_done, overrun} !== 4'b0000) begin
            n_err++; $display("FAIL rst_mid_flags: got %b want 0000", {draw_en, busy, frame_done, overrun}); end
        n_vec++; if ({x_out, y_out, w_out, h_out, c_out} !== 28'd0) begin
            n_err++; $display("FAIL rst_mid_data: got %h want 0", {x_out, y_out, w_out, h_out, c_out}); end
        step();
        reset = 1'b0;
        step();
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_fd: got %b want 0", frame_done); end
        run_pass(0, 0);
        n_vec++; if (n_win !== 0) begin n_err++; $display("FAIL rst_after_nwin: got %0d want 0", n_win); end
        n_vec++; if (done_cyc !== 18) begin n_err++; $display("FAIL rst_after_done: got %0d want 18", done_cyc); end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; obj_we = 1'b0; obj_idx = '0; obj_x = '0; obj_y = '0;
        obj_w = '0; obj_h = '0; obj_c = '0; obj_valid = 1'b0; draw_done = 1'b0;
        test_reset();
        test_idle_pass();
        test_single_object();
        test_move();
        test_skip_order();
        test_overrun();
        test_commit_write();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
